// File: rtl/scanner_pkg.sv
// Shared types and defaults for the ScannerVertical scan-chain master.
package scanner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETUP,
        HIGH,
        DONE
    } scan_state_e;

    localparam int unsigned CHAIN_LEN_DEF = 4;
    localparam int unsigned DIV_DEF       = 2;
    localparam int unsigned CLEAR_CYCLES  = 2 * DIV_DEF;

    // Chain reset pulse length: one full scan-clock period.
    function automatic int unsigned clear_cycles(input int unsigned div);
        return 2 * div;
    endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// DIV-cycle down-counter; phase_last_c flags the final cycle of a scan phase.
module scan_phase_timer
    import scanner_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic phase_last_c
);

    localparam int unsigned CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] div_cnt;

    // Reload on every phase boundary, park at zero between phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (start) begin
            div_cnt <= CNT_W'(DIV);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - CNT_W'(1);
        end
    end

    assign phase_last_c = (div_cnt == CNT_W'(1));

endmodule

// File: rtl/scanner_vertical_driver.sv
// Scan-chain master for sky130_hilas_ScannerVertical: shifts a word in MSB-first
// over a divided scan clock and returns the previous chain contents.
module scanner_vertical_driver
    import scanner_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned DIV       = DIV_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CHAIN_LEN-1:0] wr_data,
    input  logic                 clear_req,
    output logic                 rd_valid,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 busy,
    output logic                 scan_d,
    output logic                 scan_clk,
    output logic                 scan_reset_b,
    input  logic                 scan_q
);

    localparam int unsigned BIT_W        = $clog2(CHAIN_LEN + 1);
    localparam int unsigned CLEAR_PHASES = clear_cycles(DIV) / DIV;
    localparam int unsigned CLR_W        = (CLEAR_PHASES > 1) ? $clog2(CLEAR_PHASES) : 1;

    scan_state_e state, state_next;

    logic [CHAIN_LEN-1:0] sr, sr_next;
    logic [CHAIN_LEN-1:0] cap, cap_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic [CLR_W-1:0]     clr_ph, clr_ph_next;
    logic                 timer_start_c;
    logic                 phase_last_c;

    logic                 rd_valid_next;
    logic [CHAIN_LEN-1:0] rd_data_next;
    logic                 busy_next;
    logic                 scan_d_next;
    logic                 scan_clk_next;
    logic                 scan_reset_b_next;

    scan_phase_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk          (CLK),
        .rst_n        (RESET_B),
        .start        (timer_start_c),
        .phase_last_c (phase_last_c)
    );

    assign start_ready = (state == IDLE) && !clear_req;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next    = state;
        sr_next       = sr;
        cap_next      = cap;
        bit_cnt_next  = bit_cnt;
        clr_ph_next   = clr_ph;
        timer_start_c = 1'b0;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next    = CLEAR;
                    clr_ph_next   = '0;
                    timer_start_c = 1'b1;
                end else if (start_valid) begin
                    state_next    = SETUP;
                    sr_next       = wr_data;
                    bit_cnt_next  = '0;
                    timer_start_c = 1'b1;
                end
            end
            CLEAR: begin
                if (phase_last_c) begin
                    if (clr_ph == CLR_W'(CLEAR_PHASES - 1)) begin
                        state_next = IDLE;
                    end else begin
                        clr_ph_next   = clr_ph + CLR_W'(1);
                        timer_start_c = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase_last_c) begin
                    cap_next      = (cap << 1) | CHAIN_LEN'(scan_q);
                    state_next    = HIGH;
                    timer_start_c = 1'b1;
                end
            end
            HIGH: begin
                if (phase_last_c) begin
                    sr_next      = sr << 1;
                    bit_cnt_next = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(CHAIN_LEN - 1)) begin
                        state_next = DONE;
                    end else begin
                        state_next    = SETUP;
                        timer_start_c = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they come straight from flops.
        scan_clk_next     = (state_next == HIGH);
        busy_next         = (state_next != IDLE);
        rd_valid_next     = (state_next == DONE);
        scan_reset_b_next = (state_next != CLEAR);
        rd_data_next      = (state_next == DONE) ? cap_next : rd_data;
        case (state_next)
            SETUP:   scan_d_next = sr_next[CHAIN_LEN-1];
            HIGH:    scan_d_next = scan_d;
            default: scan_d_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state   <= IDLE;
            sr      <= '0;
            cap     <= '0;
            bit_cnt <= '0;
            clr_ph  <= '0;
        end else begin
            state   <= state_next;
            sr      <= sr_next;
            cap     <= cap_next;
            bit_cnt <= bit_cnt_next;
            clr_ph  <= clr_ph_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            busy         <= 1'b0;
            scan_d       <= 1'b0;
            scan_clk     <= 1'b0;
            scan_reset_b <= 1'b0;
        end else begin
            rd_valid     <= rd_valid_next;
            rd_data      <= rd_data_next;
            busy         <= busy_next;
            scan_d       <= scan_d_next;
            scan_clk     <= scan_clk_next;
            scan_reset_b <= scan_reset_b_next;
        end
    end

endmodule
